// File: rtl/multicycle_control_unit_if.sv
// Instruction-source, data-memory and datapath-strobe bundle of the multicycle control unit.
// master = control unit side, slave = datapath / instruction source side.
interface multicycle_control_unit_if #(
    parameter int OPCODELEN = 7,
    parameter int ALUOPLEN  = 3
);
    logic [OPCODELEN-1:0] opcode;
    logic                 instrValid;
    logic                 instrReady;
    logic                 memAck;
    logic                 trapClr;
    logic                 pcWri;
    logic                 irWri;
    logic                 branch;
    logic                 memRea;
    logic                 memWri;
    logic                 memToReg;
    logic                 aluSrc;
    logic                 regWri;
    logic [ALUOPLEN-1:0]  aluOp;
    logic                 illegal;
    logic                 busy;

    modport master (
        input  opcode, instrValid, memAck, trapClr,
        output instrReady, pcWri, irWri, branch, memRea, memWri,
               memToReg, aluSrc, regWri, aluOp, illegal, busy
    );

    modport slave (
        output opcode, instrValid, memAck, trapClr,
        input  instrReady, pcWri, irWri, branch, memRea, memWri,
               memToReg, aluSrc, regWri, aluOp, illegal, busy
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP with per-state datapath strobes.
// Optional retired-instruction counter enabled by defining CU_RETIRE_CNT_EN.
module multicycle_control_unit #(
    parameter int OPCODELEN = 7,
    parameter int ALUOPLEN  = 3,
    parameter int CNTW      = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    multicycle_control_unit_if.master   bus
`ifdef CU_RETIRE_CNT_EN
    ,
    output logic [CNTW-1:0]             retireCnt
`endif
);

    if (OPCODELEN < 7 || ALUOPLEN < 3 || CNTW < 1) begin : g_bad_param
        $error("multicycle_control_unit: OPCODELEN>=7, ALUOPLEN>=3, CNTW>=1 required");
    end

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_e;

    typedef struct packed {
        logic       branch;
        logic       memRea;
        logic       memWri;
        logic       memToReg;
        logic       aluSrc;
        logic       regWri;
        logic       pcWri;
        logic       illegal;
        logic       busy;
        logic [2:0] aluOp;
    } strobe_t;

    state_e               state_q, state_d;
    logic [OPCODELEN-1:0] opcode_q, opcode_d;
    strobe_t              strb_q;
    logic                 fetch_hs;

    function automatic logic is_legal(input logic [OPCODELEN-1:0] opc);
        logic [OPCODELEN-1:0] hi;
        hi = opc >> 7;
        return (hi == '0) && (opc[6:0] inside {OP_R, OP_I, OP_LOAD, OP_STORE,
                                               OP_BRANCH, OP_JAL, OP_LUI});
    endfunction

    // Strobes are a pure function of (state, opcode); registering them from the
    // next-state values keeps them aligned with state_q.
    function automatic strobe_t decode_strobes(input state_e st, input logic [6:0] op);
        strobe_t s;
        s      = '0;
        s.busy = (st != S_FETCH);
        case (st)
            S_EXEC: begin
                case (op)
                    OP_R:              s.aluOp = 3'b010;
                    OP_I:              begin s.aluOp = 3'b011; s.aluSrc = 1'b1; end
                    OP_LOAD, OP_STORE: s.aluSrc = 1'b1;
                    OP_BRANCH:         begin s.aluOp = 3'b001; s.branch = 1'b1; end
                    OP_LUI:            begin s.aluOp = 3'b100; s.aluSrc = 1'b1; end
                    default:           s.aluOp = 3'b000;
                endcase
            end
            S_MEM: begin
                s.memRea = (op == OP_LOAD);
                s.memWri = (op == OP_STORE);
                s.aluSrc = 1'b1;
            end
            S_WB: begin
                s.regWri   = 1'b1;
                s.memToReg = (op == OP_LOAD);
                s.pcWri    = (op == OP_JAL);
            end
            S_TRAP:  s.illegal = 1'b1;
            default: s.busy = (st != S_FETCH);
        endcase
        return s;
    endfunction

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            S_FETCH: begin
                if (bus.instrValid) begin
                    state_d  = S_DECODE;
                    opcode_d = bus.opcode;
                end
            end
            S_DECODE: state_d = is_legal(opcode_q) ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (opcode_q[6:0] == OP_BRANCH)
                    state_d = S_FETCH;
                else if (opcode_q[6:0] == OP_LOAD || opcode_q[6:0] == OP_STORE)
                    state_d = S_MEM;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                if (bus.memAck)
                    state_d = (opcode_q[6:0] == OP_LOAD) ? S_WB : S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  if (bus.trapClr) state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            strb_q   <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            strb_q   <= decode_strobes(state_d, opcode_d[6:0]);
        end
    end

    // Only the fetch handshake strobes see instrValid/rst combinationally.
    assign fetch_hs       = (state_q == S_FETCH) && bus.instrValid && !rst;
    assign bus.instrReady = (state_q == S_FETCH) && !rst;
    assign bus.irWri      = fetch_hs;
    assign bus.pcWri      = fetch_hs | strb_q.pcWri;
    assign bus.branch     = strb_q.branch;
    assign bus.memRea     = strb_q.memRea;
    assign bus.memWri     = strb_q.memWri;
    assign bus.memToReg   = strb_q.memToReg;
    assign bus.aluSrc     = strb_q.aluSrc;
    assign bus.regWri     = strb_q.regWri;
    assign bus.illegal    = strb_q.illegal;
    assign bus.busy       = strb_q.busy;
    assign bus.aluOp      = ALUOPLEN'(strb_q.aluOp);

`ifdef CU_RETIRE_CNT_EN
    logic [CNTW-1:0] cnt_q;
    logic            retire;

    // A trapped instruction leaves TRAP without retiring.
    assign retire = (state_q == S_WB)
                 || (state_q == S_EXEC && opcode_q[6:0] == OP_BRANCH)
                 || (state_q == S_MEM && bus.memAck && opcode_q[6:0] == OP_STORE);

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (retire)
            cnt_q <= cnt_q + 1'b1;
    end

    assign retireCnt = cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench for multicycle_control_unit; retireCnt checks only when CU_RETIRE_CNT_EN is defined.
module tb_multicycle_control_unit;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Observed word layout: {aluOp[2:0], pcWri, irWri, branch, memRea, memWri,
    //                        memToReg, aluSrc, regWri, illegal, busy, instrReady}
    localparam logic [13:0] RDY    = 14'h0001;
    localparam logic [13:0] BSY    = 14'h0002;
    localparam logic [13:0] ILL    = 14'h0004;
    localparam logic [13:0] RW     = 14'h0008;
    localparam logic [13:0] SRC    = 14'h0010;
    localparam logic [13:0] M2R    = 14'h0020;
    localparam logic [13:0] MW     = 14'h0040;
    localparam logic [13:0] MR     = 14'h0080;
    localparam logic [13:0] BR     = 14'h0100;
    localparam logic [13:0] IR     = 14'h0200;
    localparam logic [13:0] PC     = 14'h0400;
    localparam logic [13:0] AL_SUB = 14'h0800;
    localparam logic [13:0] AL_R   = 14'h1000;
    localparam logic [13:0] AL_I   = 14'h1800;
    localparam logic [13:0] AL_B   = 14'h2000;

    logic        clk;
    logic        rst;
    logic [13:0] obs;
    int          n_vec;
    int          n_err;
    logic [31:0] exp_cnt;

    multicycle_control_unit_if #(.OPCODELEN(7), .ALUOPLEN(3)) ifc ();

`ifdef CU_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    multicycle_control_unit #(
        .OPCODELEN (7),
        .ALUOPLEN  (3),
        .CNTW      (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifc.master)
`ifdef CU_RETIRE_CNT_EN
        ,
        .retireCnt (retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {ifc.aluOp, ifc.pcWri, ifc.irWri, ifc.branch, ifc.memRea, ifc.memWri,
                  ifc.memToReg, ifc.aluSrc, ifc.regWri, ifc.illegal, ifc.busy, ifc.instrReady};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_cnt(input string tag);
`ifdef CU_RETIRE_CNT_EN
        chk(tag, retire_cnt, exp_cnt);
`else
        if (tag.len() == 0) exp_cnt = exp_cnt;
`endif
    endtask

    // Inputs are set at posedge+1; outputs checked at posedge+2, then advance one cycle.
    task automatic step(input logic [13:0] exp, input string tag);
        #1;
        chk(tag, {18'd0, obs}, {18'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        exp_cnt = 0;
        rst            = 1'b1;
        ifc.instrValid = 1'b1;
        ifc.opcode     = OP_R;
        ifc.memAck     = 1'b1;
        ifc.trapClr    = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        chk("reset_outputs", {18'd0, obs}, 32'd0);
        chk_cnt("reset_cnt");

        // R-type with handshake on the first cycle out of reset
        rst = 1'b0;
        ifc.memAck = 1'b0;
        step(PC | IR | RDY, "r_hs");
        ifc.instrValid = 1'b0;
        ifc.opcode     = 7'h7f;
        step(BSY, "r_dec");
        step(AL_R | BSY, "r_exec");
        step(RW | BSY, "r_wb");
        exp_cnt = 1;
        chk_cnt("r_cnt");
        step(RDY, "r_ready");

        // I-ALU, then LUI back-to-back on the return to FETCH
        ifc.instrValid = 1'b1;
        ifc.opcode     = OP_I;
        step(PC | IR | RDY, "i_hs");
        ifc.instrValid = 1'b0;
        step(BSY, "i_dec");
        step(AL_I | SRC | BSY, "i_exec");
        step(RW | BSY, "i_wb");
        ifc.instrValid = 1'b1;
        ifc.opcode     = OP_LUI;
        step(PC | IR | RDY, "lui_hs");
        ifc.instrValid = 1'b0;
        step(BSY, "lui_dec");
        step(AL_B | SRC | BSY, "lui_exec");
        step(RW | BSY, "lui_wb");

        // JAL writes the PC again in WB
        ifc.instrValid = 1'b1;
        ifc.opcode     = OP_JAL;
        step(PC | IR | RDY, "jal_hs");
        ifc.instrValid = 1'b0;
        step(BSY, "jal_dec");
        step(BSY, "jal_exec");
        step(RW | PC | BSY, "jal_wb");
        exp_cnt = 4;
        chk_cnt("jal_cnt");
        step(RDY, "idle");

        // LOAD with memAck arriving on the fourth MEM cycle
        ifc.instrValid = 1'b1;
        ifc.opcode     = OP_LOAD;
        step(PC | IR | RDY, "ld_hs");
        ifc.instrValid = 1'b0;
        step(BSY, "ld_dec");
        step(SRC | BSY, "ld_exec");
        for (int i = 0; i < 3; i++) step(MR | SRC | BSY, "ld_mem_wait");
        ifc.memAck = 1'b1;
        step(MR | SRC | BSY, "ld_mem_ack");
        ifc.memAck = 1'b0;
        step(RW | M2R | BSY, "ld_wb");
        exp_cnt = 5;
        chk_cnt("ld_cnt");
        step(RDY, "ld_ready");

        // STORE with immediate ack, BRANCH handshaken the cycle FETCH returns
        ifc.instrValid = 1'b1;
        ifc.opcode     = OP_STORE;
        step(PC | IR | RDY, "st_hs");
        ifc.instrValid = 1'b0;
        step(BSY, "st_dec");
        step(SRC | BSY, "st_exec");
        ifc.memAck = 1'b1;
        step(MW | SRC | BSY, "st_mem");
        ifc.memAck     = 1'b0;
        ifc.instrValid = 1'b1;
        ifc.opcode     = OP_BRANCH;
        step(PC | IR | RDY, "br_hs");
        ifc.instrValid = 1'b0;
        step(BSY, "br_dec");
        step(AL_SUB | BR | BSY, "br_exec");
        exp_cnt = 7;
        chk_cnt("st_br_cnt");
        step(RDY, "br_ready");

        // Illegal 1111111 holds TRAP while other inputs toggle
        ifc.instrValid = 1'b1;
        ifc.opcode     = 7'b1111111;
        step(PC | IR | RDY, "ill_hs");
        ifc.instrValid = 1'b0;
        step(BSY, "ill_dec");
        for (int i = 0; i < 10; i++) begin
            ifc.memAck     = i[0];
            ifc.instrValid = ~i[0];
            step(ILL | BSY, "trap_hold");
        end
        ifc.memAck     = 1'b0;
        ifc.instrValid = 1'b0;
        ifc.trapClr    = 1'b1;
        step(ILL | BSY, "trap_clr");
        ifc.trapClr = 1'b0;
        chk_cnt("trap_cnt");
        step(RDY, "trap_exit");

        // JALR-shaped opcode is not supported; trapClr on the first TRAP cycle
        ifc.instrValid = 1'b1;
        ifc.opcode     = 7'b1100111;
        step(PC | IR | RDY, "ill2_hs");
        ifc.instrValid = 1'b0;
        step(BSY, "ill2_dec");
        ifc.trapClr = 1'b1;
        step(ILL | BSY, "ill2_trap");
        ifc.trapClr = 1'b0;
        step(RDY, "ill2_exit");

        // Reset during MEM of a LOAD with memAck low
        ifc.instrValid = 1'b1;
        ifc.opcode     = OP_LOAD;
        step(PC | IR | RDY, "rl_hs");
        ifc.instrValid = 1'b0;
        step(BSY, "rl_dec");
        step(SRC | BSY, "rl_exec");
        step(MR | SRC | BSY, "rl_mem");
        rst            = 1'b1;
        ifc.instrValid = 1'b1;
        step(MR | SRC | BSY, "rl_mem_rst");
        #1;
        chk("rl_rst_edge", {18'd0, obs}, 32'd0);
        exp_cnt = 0;
        chk_cnt("rl_rst_cnt");
        rst            = 1'b0;
        ifc.instrValid = 1'b0;
        step(RDY, "rl_fetch");
        ifc.memAck = 1'b1;
        step(RDY, "rl_no_wb");
        ifc.memAck = 1'b0;
        step(RDY, "rl_idle");
        chk_cnt("rl_final_cnt");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
